pkt_queue: RTL and testbench

Frame-aware FIFO: the next generation of the plain byte queue, carrying a last-word flag per entry and releasing data to the reader only once a whole frame is committed. Partial frames are rolled back on abort or overflow. Sits between the Ethernet RX path (MAC/checksum stage) and the ROS 2 packet parser, so the parser never sees truncated or errored frames.

---
 rtl/pkt_queue_pkg.sv | 24 ++
 rtl/pkt_queue_mem.sv | 26 ++
 rtl/pkt_queue.sv | 150 +++++++++++++++
 tb/tb_pkt_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_queue_pkg.sv
// Shared types and helpers for the frame-aware packet queue.
// Covers the write-FSM states, pointer sizing and {last, data} entry layout.
package pkt_queue_pkg;

  typedef enum logic [0:0] {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } wr_state_e;

  // One extra pointer bit distinguishes full from empty when addresses match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

  // Entries are packed as {last, data}, so the last flag sits just above the payload.
  function automatic int last_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/pkt_queue_mem.sv
// Entry storage for pkt_queue: one synchronous write port and one asynchronous read port.
// The read is combinational so the head entry falls through to the reader without delay.
module pkt_queue_mem #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_queue.sv
// Frame-aware FIFO: words become readable only once their frame's last word is written.
// Partial frames are rolled back to the commit pointer on abort or overflow.
module pkt_queue
  import pkt_queue_pkg::*;
#(
  parameter int          DATA_WIDTH   = 8,
  parameter int          DEPTH        = 2048,
  parameter int unsigned AFULL_MARGIN = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_last,
  input  logic                        s_abort,
  output logic                        m_valid,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic [$clog2(DEPTH):0]      level,
  output logic [$clog2(DEPTH):0]      frame_cnt,
  output logic                        almost_full,
  output logic                        drop
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int EW = entry_width(DATA_WIDTH);
  localparam int LB = last_bit(DATA_WIDTH);
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_PTR   = PW'(1);

  wr_state_e state_reg, state_next;
  logic [PW-1:0] wp_reg, wp_next;
  logic [PW-1:0] wc_reg, wc_next;
  logic [PW-1:0] rp_reg, rp_next;
  logic [PW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          drop_reg, drop_next;

  logic          mem_we;
  logic          commit;
  logic          full;
  logic          pop;
  logic          pop_last;
  logic [PW-1:0] wp_inc;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] free_entries;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  pkt_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wp_reg[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rp_reg[AW-1:0]),
    .rdata (rd_entry)
  );

  assign wr_entry = {s_last, s_data};
  assign wp_inc   = wp_reg + ONE_PTR;

  // Status is derived from registered pointers only; a same-cycle read never frees room for a write.
  assign occupancy    = wp_reg - rp_reg;
  assign full         = (occupancy == DEPTH_PTR);
  assign free_entries = DEPTH_PTR - occupancy;

  assign m_valid     = (rp_reg != wc_reg);
  assign m_data      = m_valid ? rd_entry[DATA_WIDTH-1:0] : '0;
  assign m_last      = m_valid & rd_entry[LB];
  assign level       = occupancy;
  assign frame_cnt   = frame_cnt_reg;
  assign almost_full = (32'(free_entries) <= AFULL_MARGIN);
  assign drop        = drop_reg;

  assign pop      = m_valid & m_ready;
  assign pop_last = pop & m_last;

  always_comb begin
    state_next = state_reg;
    wp_next    = wp_reg;
    wc_next    = wc_reg;
    drop_next  = 1'b0;
    mem_we     = 1'b0;
    commit     = 1'b0;
    unique case (state_reg)
      ACCEPT: begin
        if (s_abort) begin
          wp_next   = wc_reg;
          drop_next = (wp_reg != wc_reg) | s_valid;
        end else if (s_valid && full) begin
          // Overflow: roll back and swallow the rest of the frame unless this word ends it.
          wp_next   = wc_reg;
          drop_next = 1'b1;
          if (!s_last) begin
            state_next = DISCARD;
          end
        end else if (s_valid) begin
          mem_we  = 1'b1;
          wp_next = wp_inc;
          if (s_last) begin
            wc_next = wp_inc;
            commit  = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (s_abort || (s_valid && s_last)) begin
          state_next = ACCEPT;
        end
      end
      default: begin
        state_next = ACCEPT;
      end
    endcase
  end

  always_comb begin
    rp_next        = pop ? rp_reg + ONE_PTR : rp_reg;
    frame_cnt_next = frame_cnt_reg;
    unique case ({commit, pop_last})
      2'b10:   frame_cnt_next = frame_cnt_reg + ONE_PTR;
      2'b01:   frame_cnt_next = frame_cnt_reg - ONE_PTR;
      default: frame_cnt_next = frame_cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ACCEPT;
      wp_reg        <= '0;
      wc_reg        <= '0;
      rp_reg        <= '0;
      frame_cnt_reg <= '0;
      drop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wp_reg        <= wp_next;
      wc_reg        <= wc_next;
      rp_reg        <= rp_next;
      frame_cnt_reg <= frame_cnt_next;
      drop_reg      <= drop_next;
    end
  end

endmodule

// File: tb/tb_pkt_queue.sv
// Directed bench for pkt_queue at DEPTH=8, AFULL_MARGIN=2.
// Expected values are hand-computed from the pointer arithmetic of each step.
module tb_pkt_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_abort;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic [3:0] level;
  logic [3:0] frame_cnt;
  logic       almost_full;
  logic       drop;

  int errors = 0;
  int checks = 0;

  logic [7:0] fa [4];
  logic [7:0] ga [4];
  logic [7:0] ca [5];

  pkt_queue #(
    .DATA_WIDTH   (8),
    .DEPTH        (8),
    .AFULL_MARGIN (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_abort     (s_abort),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .level       (level),
    .frame_cnt   (frame_cnt),
    .almost_full (almost_full),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_abort = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_abort = 1'b0;
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_data"},  32'(m_data), 0);
    chk({tag, "_m_last"},  32'(m_last), 0);
    chk({tag, "_level"},   32'(level), 0);
    chk({tag, "_fcnt"},    32'(frame_cnt), 0);
    chk({tag, "_afull"},   32'(almost_full), 0);
    chk({tag, "_drop"},    32'(drop), 0);
  endtask

  initial begin
    fa = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
    ga = '{8'h60, 8'h61, 8'h62, 8'h63};
    ca = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    rst = 1'b1;
    m_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk_reset("reset");

    // Frame A, reader always ready: invisible until the cycle after A3.
    m_ready = 1'b1;
    wr(8'hA1, 1'b0);
    chk("a_hidden1", 32'(m_valid), 0);
    chk("a_level1", 32'(level), 1);
    wr(8'hA2, 1'b0);
    chk("a_hidden2", 32'(m_valid), 0);
    wr(8'hA3, 1'b1);
    idle();
    chk("a_valid", 32'(m_valid), 1);
    chk("a_d1", 32'(m_data), 32'hA1);
    chk("a_l1", 32'(m_last), 0);
    chk("a_fcnt1", 32'(frame_cnt), 1);
    tick();
    chk("a_d2", 32'(m_data), 32'hA2);
    chk("a_l2", 32'(m_last), 0);
    tick();
    chk("a_d3", 32'(m_data), 32'hA3);
    chk("a_l3", 32'(m_last), 1);
    tick();
    chk("a_empty", 32'(m_valid), 0);
    chk("a_fcnt0", 32'(frame_cnt), 0);
    chk("a_level0", 32'(level), 0);

    // Two words then abort; then a 1-word frame B.
    wr(8'h11, 1'b0);
    wr(8'h12, 1'b0);
    chk("ab_level2", 32'(level), 2);
    chk("ab_hidden", 32'(m_valid), 0);
    idle();
    s_abort = 1'b1;
    tick();
    idle();
    chk("ab_drop", 32'(drop), 1);
    chk("ab_level0", 32'(level), 0);
    chk("ab_hidden2", 32'(m_valid), 0);
    tick();
    chk("ab_drop_once", 32'(drop), 0);
    wr(8'hB0, 1'b1);
    idle();
    chk("b_valid", 32'(m_valid), 1);
    chk("b_data", 32'(m_data), 32'hB0);
    chk("b_last", 32'(m_last), 1);
    tick();
    chk("b_empty", 32'(m_valid), 0);

    // Overflow: 5-word frame committed, second frame overflows on its 4th word.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(ca[i], i == 4);
    chk("ov_level5", 32'(level), 5);
    chk("ov_fcnt1", 32'(frame_cnt), 1);
    chk("ov_afull5", 32'(almost_full), 0);
    wr(8'hD0, 1'b0);
    chk("ov_level6", 32'(level), 6);
    chk("ov_afull6", 32'(almost_full), 1);
    wr(8'hD1, 1'b0);
    wr(8'hD2, 1'b0);
    chk("ov_full", 32'(level), 8);
    chk("ov_nodrop", 32'(drop), 0);
    wr(8'hD3, 1'b0);
    chk("ov_drop", 32'(drop), 1);
    chk("ov_rollback", 32'(level), 5);
    wr(8'hD4, 1'b1);
    chk("ov_drop_once", 32'(drop), 0);
    chk("ov_ignored", 32'(level), 5);
    chk("ov_fcnt", 32'(frame_cnt), 1);
    wr(8'hE0, 1'b1);
    idle();
    chk("ov_accept_level", 32'(level), 6);
    chk("ov_accept_fcnt", 32'(frame_cnt), 2);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ov_rd_c%0d", i), 32'(m_data), 32'(ca[i]));
      chk($sformatf("ov_rl_c%0d", i), 32'(m_last), (i == 4) ? 1 : 0);
      tick();
    end
    chk("ov_rd_e0", 32'(m_data), 32'hE0);
    chk("ov_fcnt_e", 32'(frame_cnt), 1);
    tick();
    chk("ov_drained", 32'(m_valid), 0);
    chk("ov_fcnt0", 32'(frame_cnt), 0);

    // Wrap: frame F at pointers 10..13, frame G at 14,15,0,1 written while F drains.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(fa[i], i == 3);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = ga[i];
      s_last  = (i == 3);
      chk($sformatf("wr_rd_f%0d", i), 32'(m_data), 32'(fa[i]));
      chk($sformatf("wr_lvl_f%0d", i), 32'(level), 4);
      if (i == 3) chk("wr_fcnt_pre", 32'(frame_cnt), 1);
      tick();
    end
    idle();
    chk("wr_fcnt_same", 32'(frame_cnt), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_rd_g%0d", i), 32'(m_data), 32'(ga[i]));
      chk($sformatf("wr_rl_g%0d", i), 32'(m_last), (i == 3) ? 1 : 0);
      tick();
    end
    chk("wr_empty", 32'(m_valid), 0);
    chk("wr_fcnt0", 32'(frame_cnt), 0);

    // Reset with a committed frame and a partial frame pending.
    m_ready = 1'b0;
    wr(8'h70, 1'b1);
    wr(8'h71, 1'b0);
    wr(8'h72, 1'b0);
    chk("rs_level3", 32'(level), 3);
    chk("rs_fcnt1", 32'(frame_cnt), 1);
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h73;
    tick();
    rst = 1'b0;
    idle();
    chk_reset("midrst");
    wr(8'h80, 1'b0);
    wr(8'h81, 1'b1);
    idle();
    chk("rs_new_valid", 32'(m_valid), 1);
    chk("rs_new_d0", 32'(m_data), 32'h80);
    chk("rs_new_level", 32'(level), 2);
    m_ready = 1'b1;
    tick();
    chk("rs_new_d1", 32'(m_data), 32'h81);
    chk("rs_new_l1", 32'(m_last), 1);
    tick();
    chk("rs_new_empty", 32'(m_valid), 0);

    // almost_full on uncommitted words, cleared by abort.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h90 + 8'(i), 1'b0);
    chk("af_lvl5", 32'(almost_full), 0);
    wr(8'h95, 1'b0);
    chk("af_lvl6", 32'(almost_full), 1);
    chk("af_level6", 32'(level), 6);
    idle();
    s_abort = 1'b1;
    tick();
    idle();
    chk("af_cleared", 32'(almost_full), 0);
    chk("af_drop", 32'(drop), 1);
    chk("af_level0", 32'(level), 0);
    tick();
    chk("af_drop_once", 32'(drop), 0);
    chk("af_hidden", 32'(m_valid), 0);

    // Abort with nothing pending: no drop; abort alongside a valid word: drop.
    s_abort = 1'b1;
    tick();
    chk("abort_idle_nodrop", 32'(drop), 0);
    s_valid = 1'b1;
    s_data  = 8'h55;
    tick();
    idle();
    chk("abort_valid_drop", 32'(drop), 1);
    chk("abort_valid_level", 32'(level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
